// File: rtl/led_cube_pkg.sv
// Shared definitions for the LED-cube scan drivers: FSM states, cube
// geometry and the 3-to-8 one-hot decode used for layers and row latches.
package led_cube_pkg;

  localparam int NUM_LAYERS     = 8;
  localparam int ROWS_PER_LAYER = 8;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    SETUP   = 3'd1,
    STROBE  = 3'd2,
    RELEASE = 3'd3,
    SHOW    = 3'd4
  } state_e;

  // 3-bit index to one-hot byte
  function automatic logic [7:0] onehot8(input logic [2:0] idx);
    return 8'b0000_0001 << idx;
  endfunction

endpackage

// File: rtl/led_cube_single_frame_if.sv
// Frame-scan bus between the animation controller (master) and the
// single-frame scan driver (slave): control, frame fetch and cube drive pins.
interface led_cube_single_frame_if;
  logic       start;
  logic       stop;
  logic       done;
  logic [5:0] addr;
  logic [7:0] data_to_latch;
  logic [7:0] Layers;
  logic [7:0] Latches;
  logic [7:0] Data;

  modport master (
    output start, stop, data_to_latch,
    input  done, addr, Layers, Latches, Data
  );

  modport slave (
    input  start, stop, data_to_latch,
    output done, addr, Layers, Latches, Data
  );
endinterface

// File: rtl/led_cube_single_frame.sv
// Scan driver for one 8x8x8 frame. Walks {layer,row} byte addresses,
// strobes each byte into its row latch (SETUP/STROBE/RELEASE, 3 cycles per
// row), then enables the layer for LAYER_HOLD cycles, rescanning forever.
// Build option: LED_CUBE_BLANKING_EN blanks Layers while rows are loading;
// without it the previously shown layer stays lit until the next SHOW.
module led_cube_single_frame
  import led_cube_pkg::*;
#(
  parameter int LAYER_HOLD = 2000
) (
  input  logic                    clk,
  input  logic                    rst,
  led_cube_single_frame_if.slave  bus
);

  localparam int HW = $clog2(LAYER_HOLD + 1);
  localparam logic [HW-1:0] HOLD_LAST = HW'(LAYER_HOLD - 1);

  state_e        state_q;
  logic [2:0]    layer_q;
  logic [2:0]    row_q;
  logic [HW-1:0] hold_q;
  logic [7:0]    data_q;
  logic          done_q;

  // Main scan FSM with row/layer/hold counters; rst > stop > start
  always_ff @(posedge clk) begin
    if (rst || bus.stop) begin
      state_q <= IDLE;
      layer_q <= '0;
      row_q   <= '0;
      hold_q  <= '0;
      data_q  <= '0;
      done_q  <= 1'b0;
    end else if (bus.start) begin
      state_q <= SETUP;
      layer_q <= '0;
      row_q   <= '0;
      hold_q  <= '0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: ;
        SETUP: begin
          data_q  <= bus.data_to_latch;
          state_q <= STROBE;
        end
        STROBE: state_q <= RELEASE;
        RELEASE: begin
          if (row_q == 3'd7) begin
            row_q   <= '0;
            state_q <= SHOW;
          end else begin
            row_q   <= row_q + 3'd1;
            state_q <= SETUP;
          end
        end
        SHOW: begin
          if (hold_q == HOLD_LAST) begin
            hold_q  <= '0;
            layer_q <= layer_q + 3'd1;
            state_q <= SETUP;
            // pulse lands on the first SETUP of the next pass
            done_q  <= (layer_q == 3'd7);
          end else begin
            hold_q <= hold_q + 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.addr    = (state_q == IDLE) ? 6'd0 : {layer_q, row_q};
  assign bus.Latches = (state_q == STROBE) ? onehot8(row_q) : 8'd0;
  assign bus.Data    = data_q;
  assign bus.done    = done_q;

`ifdef LED_CUBE_BLANKING_EN
  assign bus.Layers = (state_q == SHOW) ? onehot8(layer_q) : 8'd0;
`else
  logic [2:0] lay_q;
  logic       lay_vld_q;

  // Remember the last shown layer so it stays lit while the next one loads
  always_ff @(posedge clk) begin
    if (rst || bus.stop || bus.start) begin
      lay_q     <= '0;
      lay_vld_q <= 1'b0;
    end else if (state_q == RELEASE && row_q == 3'd7) begin
      lay_q     <= layer_q;
      lay_vld_q <= 1'b1;
    end
  end

  assign bus.Layers = lay_vld_q ? onehot8(lay_q) : 8'd0;
`endif

endmodule

// File: tb/tb_led_cube_single_frame.sv
// Scoreboard bench for led_cube_single_frame (LAYER_HOLD=4). The driver
// issues rst/start/stop, advances a timeline model (cycles since start) and
// queues the expected outputs; the monitor pops and compares every cycle.
module tb_led_cube_single_frame;

  localparam int H   = 4;
  localparam int LYR = 24 + H;     // cycles per layer
  localparam int P   = 8 * LYR;    // cycles per pass

  typedef struct {
    logic [5:0] addr;
    logic [7:0] layers;
    logic [7:0] latches;
    logic [7:0] data;
    logic       done;
    bit         chk_data;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  logic [7:0] frame [64];

  led_cube_single_frame_if bus();

  led_cube_single_frame #(.LAYER_HOLD(H)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  assign bus.data_to_latch = frame[bus.addr];

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  bit   m_run  = 1'b0;
  int   m_k    = 0;

  // Expected outputs from the position in the scan timeline
  function automatic exp_t model(input bit run, input int k);
    exp_t e;
    int p, l, q, row, ph;
    logic [2:0] l3, r3;
    e = '{addr: 6'd0, layers: 8'd0, latches: 8'd0, data: 8'd0, done: 1'b0, chk_data: 1'b1};
    if (!run) return e;
    p  = k % P;
    l  = p / LYR;
    q  = p % LYR;
    l3 = l[2:0];
    e.done = (k > 0) && (p == 0);
    if (q < 24) begin
      row = q / 3;
      ph  = q % 3;
      r3  = row[2:0];
      e.addr     = {l3, r3};
      e.latches  = (ph == 1) ? (8'd1 << r3) : 8'd0;
      e.chk_data = (ph != 0);
      e.data     = frame[{l3, r3}];
`ifdef LED_CUBE_BLANKING_EN
      e.layers = 8'd0;
`else
      e.layers = (k < 24) ? 8'd0 : (8'd1 << (l3 - 3'd1));
`endif
    end else begin
      e.addr   = {l3, 3'd0};
      e.layers = 8'd1 << l3;
      e.data   = frame[{l3, 3'd7}];
    end
    return e;
  endfunction

  task automatic cyc(input bit r, input bit st, input bit sp);
    @(negedge clk);
    rst       = r;
    bus.start = st;
    bus.stop  = sp;
    if (r || sp) begin
      m_run = 1'b0;
      m_k   = 0;
    end else if (st) begin
      m_run = 1'b1;
      m_k   = 0;
    end else if (m_run) begin
      m_k++;
    end
    exp_q.push_back(model(m_run, m_k));
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 1'b0);
  endtask

  task automatic check(input string nm, input logic [7:0] act, input logic [7:0] exv);
    checks++;
    if (act !== exv) begin
      errors++;
      $display("FAIL %s at %0t: got %h expected %h", nm, $time, act, exv);
    end
  endtask

  // Monitor: compare DUT outputs against the oldest queued expectation
  always @(posedge clk) begin
    exp_t e;
    #1;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check("addr",    {2'b00, bus.addr}, {2'b00, e.addr});
      check("Layers",  bus.Layers,  e.layers);
      check("Latches", bus.Latches, e.latches);
      check("done",    {7'd0, bus.done}, {7'd0, e.done});
      if (e.chk_data) check("Data", bus.Data, e.data);
    end
  end

  initial begin
    rst       = 1'b1;
    bus.start = 1'b0;
    bus.stop  = 1'b0;
    for (int i = 0; i < 64; i++) frame[i] = 8'($urandom);

    // reset and idle
    cyc(1'b1, 1'b0, 1'b0);
    cyc(1'b1, 1'b0, 1'b0);
    idle(4);
    // long run: latch order, layer timing, done at 225 then every 224
    cyc(1'b0, 1'b1, 1'b0);
    idle(2 * P + 3 * LYR + 26);  // lands mid-SHOW of layer 3
    cyc(1'b1, 1'b0, 1'b0);       // reset mid-SHOW
    idle(3);
    // stop during layer 3 loading, then restart from addr 0
    cyc(1'b0, 1'b1, 1'b0);
    idle(3 * LYR + 5);
    cyc(1'b0, 1'b0, 1'b1);
    idle(10);
    cyc(1'b0, 1'b1, 1'b0);
    // restart during layer 5 SHOW
    idle(5 * LYR + 25);
    cyc(1'b0, 1'b1, 1'b0);
    idle(P + 40);
    // start and stop together: stop wins
    cyc(1'b0, 1'b1, 1'b1);
    idle(3);
    // randomized control traffic
    for (int i = 0; i < 4000; i++) begin
      cyc($urandom_range(0, 999) == 0,
          $urandom_range(0, 249) == 0,
          $urandom_range(0, 399) == 0);
    end
    cyc(1'b0, 1'b0, 1'b1);
    idle(3);
    @(posedge clk);
    #3;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending expected 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
